// File: rtl/ro_meas_pkg.sv
// rtl/ro_meas_pkg.sv - shared types and constants for the ring-oscillator frequency meter
package ro_meas_pkg;

  // Measurement sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2
  } state_t;

  localparam int DEF_NUM_CH      = 16;
  localparam int DEF_GATE_W      = 24;
  localparam int DEF_CNT_W       = 24;
  localparam int DEF_SYNC_STAGES = 2;

  // Saturation value of the edge counter at the default width
  localparam logic [DEF_CNT_W-1:0] CNT_MAX = {DEF_CNT_W{1'b1}};

  // Channel select width, never narrower than one bit
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ro_freq_meter_if.sv
// rtl/ro_freq_meter_if.sv - oscillator inputs, control and result bundle of the frequency meter
interface ro_freq_meter_if
  import ro_meas_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = sel_width(NUM_CH),
  parameter int GATE_W = DEF_GATE_W,
  parameter int CNT_W  = DEF_CNT_W
);
  logic [NUM_CH-1:0] ro_in;
  logic [SEL_W-1:0]  ch_sel;
  logic [GATE_W-1:0] gate_cycles;
  logic              continuous;
  logic              start;
  logic              stop;
  logic              ro_out;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport master (
    output ro_in, ch_sel, gate_cycles, continuous, start, stop,
    input  ro_out, busy, done, count, overflow
  );

  modport slave (
    input  ro_in, ch_sel, gate_cycles, continuous, start, stop,
    output ro_out, busy, done, count, overflow
  );
endinterface

// File: rtl/ro_edge_sync.sv
// rtl/ro_edge_sync.sv - synchroniser chain plus rising-edge detector for one oscillator
module ro_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Resample the asynchronous input, then keep one extra sample for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~hist_q;
endmodule

// File: rtl/ro_freq_meter.sv
// rtl/ro_freq_meter.sv - oscillator pad mux with gated rising-edge frequency counter
module ro_freq_meter
  import ro_meas_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int SEL_W       = sel_width(NUM_CH),
  parameter int GATE_W      = DEF_GATE_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input logic           wb_clk_i,
  input logic           wb_rst_i,
  ro_freq_meter_if.slave bus
);
  localparam int SET_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  ch_lat;
  logic [GATE_W-1:0] gate_lat, gate_rem;
  logic              cont_lat;
  logic [SET_W-1:0]  settle_cnt;
  logic [CNT_W-1:0]  acc, acc_sum, count_q;
  logic              ovf_acc, acc_sat, overflow_q, done_q;
  logic              meas_in, ro_edge, start_ok, settle_last, window_end;

  // Live pad mux and latched measurement mux; out-of-range selects read as 0
  always_comb begin
    bus.ro_out = 1'b0;
    meas_in    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(bus.ch_sel) == i) bus.ro_out = bus.ro_in[i];
      if (int'(ch_lat) == i)     meas_in    = bus.ro_in[i];
    end
  end

  ro_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .async_in (meas_in),
    .edge_o   (ro_edge)
  );

  assign start_ok    = bus.start && (bus.gate_cycles != '0) && (int'(bus.ch_sel) < NUM_CH);
  assign settle_last = (settle_cnt == SET_W'(SYNC_STAGES));
  assign window_end  = (state == GATE) && (gate_rem == GATE_W'(1));

  // Saturating accumulate of this cycle's edge
  always_comb begin
    acc_sat = (acc == CNT_TOP) && ro_edge;
    acc_sum = acc_sat ? acc : acc + CNT_W'(ro_edge);
  end

  // Next-state logic; stop wins over a window completing in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = SETTLE;
      SETTLE:  if (bus.stop) state_nxt = IDLE;
               else if (settle_last) state_nxt = GATE;
      GATE:    if (bus.stop) state_nxt = IDLE;
               else if (window_end && !cont_lat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, settings latch, gate counter, accumulator and result registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      ch_lat     <= '0;
      gate_lat   <= '0;
      cont_lat   <= 1'b0;
      settle_cnt <= '0;
      gate_rem   <= '0;
      acc        <= '0;
      ovf_acc    <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            ch_lat     <= bus.ch_sel;
            gate_lat   <= bus.gate_cycles;
            cont_lat   <= bus.continuous;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + SET_W'(1);
          gate_rem   <= gate_lat;
          acc        <= '0;
          ovf_acc    <= 1'b0;
        end
        GATE: begin
          if (!bus.stop) begin
            if (window_end) begin
              count_q    <= acc_sum;
              overflow_q <= ovf_acc | acc_sat;
              done_q     <= 1'b1;
              gate_rem   <= gate_lat;
              acc        <= '0;
              ovf_acc    <= 1'b0;
            end else begin
              acc      <= acc_sum;
              ovf_acc  <= ovf_acc | acc_sat;
              gate_rem <= gate_rem - GATE_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_ro_freq_meter.sv
// tb/tb_ro_freq_meter.sv - directed self-checking bench for ro_freq_meter
module tb_ro_freq_meter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] osc = '0;
  int          half [16];
  int          ph   [16];

  always #5 clk = ~clk;

  ro_freq_meter_if #(.NUM_CH(16), .SEL_W(5), .GATE_W(24), .CNT_W(24)) m_if ();
  ro_freq_meter_if #(.NUM_CH(16), .SEL_W(4), .GATE_W(24), .CNT_W(4))  s_if ();

  ro_freq_meter #(.NUM_CH(16), .SEL_W(5), .GATE_W(24), .CNT_W(24), .SYNC_STAGES(2)) u_main (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (m_if)
  );

  ro_freq_meter #(.NUM_CH(16), .SEL_W(4), .GATE_W(24), .CNT_W(4), .SYNC_STAGES(2)) u_small (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (s_if)
  );

  assign m_if.ro_in = osc;
  assign s_if.ro_in = osc;

  // Oscillator models: channel i toggles every half[i] clocks, away from the sampling edge
  initial begin
    for (int i = 0; i < 16; i++) begin
      half[i] = 0;
      ph[i]   = 0;
    end
    half[1] = 1;
    half[3] = 4;
    half[5] = 5;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (half[i] != 0) begin
        if (ph[i] == half[i] - 1) begin
          ph[i]  <= 0;
          osc[i] <= ~osc[i];
        end else begin
          ph[i] <= ph[i] + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int busy_n, done_n, nd;
  int when [3];
  logic [31:0] cnts [3];
  logic [31:0] cnt_seen, ovf_seen;

  initial begin
    m_if.ch_sel = '0; m_if.gate_cycles = '0; m_if.continuous = 1'b0;
    m_if.start = 1'b0; m_if.stop = 1'b0;
    s_if.ch_sel = '0; s_if.gate_cycles = '0; s_if.continuous = 1'b0;
    s_if.start = 1'b0; s_if.stop = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("reset_busy", m_if.busy, 0);
    chk("reset_done", m_if.done, 0);
    chk("reset_count", m_if.count, 0);
    chk("reset_overflow", m_if.overflow, 0);

    // Single window, channel 3 (period 8), 800 cycles
    m_if.ch_sel = 5'd3; m_if.gate_cycles = 24'd800; m_if.continuous = 1'b0;
    chk("ro_out_ch3_a", m_if.ro_out, osc[3]);
    m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    busy_n = 0; done_n = 0; cnt_seen = '1; ovf_seen = '1;
    for (int k = 0; k < 820; k++) begin
      if (m_if.busy) busy_n++;
      if (m_if.done) begin
        done_n++;
        cnt_seen = m_if.count;
        ovf_seen = m_if.overflow;
      end
      tick();
    end
    chk("single_busy_cycles", busy_n, 803);
    chk("single_done_pulses", done_n, 1);
    chk("single_count", cnt_seen, 100);
    chk("single_overflow", ovf_seen, 0);
    chk("single_idle_after", m_if.busy, 0);
    chk("ro_out_ch3_b", m_if.ro_out, osc[3]);

    // Abort halfway through the gate window
    m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    repeat (403) tick();
    m_if.stop = 1'b1;
    tick();
    m_if.stop = 1'b0;
    chk("stop_busy", m_if.busy, 0);
    chk("stop_done", m_if.done, 0);
    chk("stop_count_kept", m_if.count, 100);
    done_n = 0;
    for (int k = 0; k < 20; k++) begin
      if (m_if.done) done_n++;
      tick();
    end
    chk("stop_no_late_done", done_n, 0);

    // Rejected starts: zero gate, then out-of-range channel
    m_if.gate_cycles = 24'd0; m_if.ch_sel = 5'd3; m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    chk("gate0_busy", m_if.busy, 0);
    chk("gate0_done", m_if.done, 0);
    m_if.gate_cycles = 24'd800; m_if.ch_sel = 5'd20; m_if.start = 1'b1;
    #1;
    chk("ro_out_sel20", m_if.ro_out, 0);
    tick();
    m_if.start = 1'b0;
    chk("sel20_busy", m_if.busy, 0);
    chk("sel20_done", m_if.done, 0);

    // Continuous windows on channel 5 (period 10); ch_sel/continuous change after start
    m_if.ch_sel = 5'd5; m_if.gate_cycles = 24'd1000; m_if.continuous = 1'b1;
    m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    m_if.continuous = 1'b0;
    m_if.ch_sel = 5'd3;
    #1;
    chk("ro_out_live_ch3", m_if.ro_out, osc[3]);
    nd = 0;
    for (int k = 0; k < 3100; k++) begin
      if (m_if.done) begin
        if (nd < 3) begin
          when[nd] = k;
          cnts[nd] = m_if.count;
        end
        nd++;
      end
      tick();
    end
    chk("cont_done_total", nd, 3);
    chk("cont_first_done_at", when[0], 1003);
    chk("cont_period_1", when[1] - when[0], 1000);
    chk("cont_period_2", when[2] - when[1], 1000);
    chk("cont_count_0", cnts[0], 100);
    chk("cont_count_1", cnts[1], 100);
    chk("cont_count_2", cnts[2], 100);
    chk("cont_count_sum", cnts[0] + cnts[1] + cnts[2], 300);
    chk("cont_still_busy", m_if.busy, 1);
    m_if.stop = 1'b1;
    tick();
    m_if.stop = 1'b0;
    chk("cont_stopped", m_if.busy, 0);

    // Narrow counter: period 2 over 100 cycles saturates, then period 8 over 40 does not
    s_if.ch_sel = 4'd1; s_if.gate_cycles = 24'd100; s_if.start = 1'b1;
    tick();
    s_if.start = 1'b0;
    done_n = 0; cnt_seen = '1; ovf_seen = '1;
    for (int k = 0; k < 120; k++) begin
      if (s_if.done) begin
        done_n++;
        cnt_seen = s_if.count;
        ovf_seen = s_if.overflow;
      end
      tick();
    end
    chk("sat_done", done_n, 1);
    chk("sat_count", cnt_seen, 15);
    chk("sat_overflow", ovf_seen, 1);
    s_if.ch_sel = 4'd3; s_if.gate_cycles = 24'd40; s_if.start = 1'b1;
    tick();
    s_if.start = 1'b0;
    done_n = 0; cnt_seen = '1; ovf_seen = '1;
    for (int k = 0; k < 60; k++) begin
      if (s_if.done) begin
        done_n++;
        cnt_seen = s_if.count;
        ovf_seen = s_if.overflow;
      end
      tick();
    end
    chk("nosat_done", done_n, 1);
    chk("nosat_count", cnt_seen, 5);
    chk("nosat_overflow", ovf_seen, 0);

    // Reset in the middle of a gate window
    m_if.ch_sel = 5'd3; m_if.gate_cycles = 24'd800; m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    repeat (400) tick();
    chk("pre_rst_busy", m_if.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", m_if.busy, 0);
    chk("rst_count", m_if.count, 0);
    chk("rst_overflow", m_if.overflow, 0);
    chk("rst_done", m_if.done, 0);
    done_n = 0;
    for (int k = 0; k < 20; k++) begin
      if (m_if.done) done_n++;
      tick();
    end
    chk("rst_no_late_done", done_n, 0);
    chk("ro_out_ch3_c", m_if.ro_out, osc[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ro_freq_meter.md
Name: ro_freq_meter

Overview:
Successor to the fixed 16:1 oscillator output mux. It takes NUM_CH ring-oscillator outputs and keeps a live passthrough mux to a pad. It adds an on-chip frequency measurement: the selected oscillator is synchronised into wb_clk_i, its rising edges are counted over a programmable gate window, and the count is reported. Single-shot and continuous modes are supported. It sits in user_project_wrapper between the oscillator macros and io_out / the Wishbone register block.

Parameters:
NUM_CH, 16, number of oscillator inputs
SEL_W, $clog2(NUM_CH) (min 1), channel select width
GATE_W, 24, gate window length width (cycles of wb_clk_i)
CNT_W, 24, edge count width
SYNC_STAGES, 2, synchroniser flops per channel path (>=2)

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  reset, synchronous, active-high
ro_in  in  NUM_CH  asynchronous oscillator outputs
ch_sel  in  SEL_W  channel select (live for ro_out, latched at start)
gate_cycles  in  GATE_W  window length in clock cycles
continuous  in  1  1 = auto-restart windows; latched at start
start  in  1  begin measurement (level sampled in IDLE)
stop  in  1  abort measurement
ro_out  out  1  combinational ro_in[ch_sel]; 0 if ch_sel >= NUM_CH
busy  out  1  high in SETTLE or GATE
done  out  1  one-cycle pulse when count updates
count  out  CNT_W  edges in last completed window
overflow  out  1  last completed window saturated

Behaviour:
- Clock and reset: one clock and one reset. wb_clk_i is the sole clock. wb_rst_i is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, count=0, overflow=0, synchroniser and edge-detect flops=0, accumulators=0. ro_out is unaffected by reset (combinational).
- Edge path: latched channel goes through SYNC_STAGES flops, then one history flop. edge = sync & ~hist. Max measurable frequency is fclk/2; higher rates alias (documented limit, not flagged).
- FSM states: IDLE, SETTLE, GATE.
- IDLE:
  - start=1 with gate_cycles!=0 and ch_sel<NUM_CH: latch ch_sel, gate_cycles and continuous; go to SETTLE.
  - Any other start is ignored, with no done pulse.
- SETTLE:
  - Lasts exactly SYNC_STAGES+1 cycles, so stale samples from the previous channel are flushed. No counting.
  - Then load gate_rem=gate_lat, acc=0, and go to GATE.
- GATE:
  - Each cycle, acc += edge. Saturate at 2^CNT_W-1 and set ovf_acc.
  - gate_rem decrements each cycle.
  - On the cycle gate_rem==1 (the last of exactly gate_lat cycles):
    - next cycle, count = acc + edge (saturated), overflow = ovf_acc, done=1 for one cycle;
    - if continuous, reload gate_rem, clear acc/ovf_acc with the current cycle's edge attributed to the finished window, and stay in GATE (no dead cycle between windows);
    - otherwise go to IDLE.
- stop=1 in SETTLE or GATE: go to IDLE next cycle. No done; count/overflow retain previous values. stop has priority over window completion in the same cycle. stop in IDLE is a no-op.
- start while busy is ignored. ch_sel changes while busy affect ro_out only, not the measurement.
- wb_rst_i mid-measurement: returns to reset values on the next edge; done is not pulsed.
- done and the count update are simultaneous. count is stable until the next done.

Decomposition:
- Package ro_meas_pkg: FSM state enum (IDLE, SETTLE, GATE), default parameter constants, and localparam CNT_MAX.
- Sub-module ro_edge_sync: SYNC_STAGES synchroniser plus rising-edge detector (clk, rst, async_in, edge_o). Instantiated once on the latched-channel mux output.
- Top holds the mux, FSM, gate counter and accumulator.

Test Plan:
- Bench model for channel 3: toggles every 4 clocks (period 8). ch_sel=3, gate_cycles=800, start pulse. Required: busy for 3+800 cycles, one done pulse, count in 99..101, overflow=0, then IDLE.
- continuous=1, channel 5 with period 10, gate_cycles=1000. Required: done every 1000 cycles exactly after the first; each count in 99..101; no missing edges across the window boundary (sum over 3 windows is 300±1).
- CNT_W overridden to 4, channel with period 2, gate_cycles=100. Required: count=15, overflow=1. A following window with period 8 and gate_cycles=40 gives count≈5 and overflow=0.
- stop asserted mid-GATE (cycle 400 of 800) after a prior count=100. Required: busy drops next cycle, no done, count stays 100.
- start with gate_cycles=0, then start with ch_sel=20 (NUM_CH=16). Required: no busy, no done; ro_out=0 for ch_sel=20.
- wb_rst_i asserted for one cycle mid-GATE. Required: next cycle busy=0, count=0, overflow=0, no done. ro_out tracks ro_in[ch_sel] combinationally throughout.
